// File: rtl/pwm_fade_pkg.sv
// Shared types and defaults for the PWM fade scheduler.
// Optional build macro: PWM_FADE_PREEMPT_EN (commands may retarget a busy channel).
package pwm_fade_pkg;

  localparam int unsigned BITS_DEF       = 7;
  localparam int unsigned INTERVAL_W_DEF = 16;
  localparam int unsigned NUM_CH_DEF     = 3;

  localparam int unsigned CH_RED   = 0;
  localparam int unsigned CH_GREEN = 1;
  localparam int unsigned CH_BLUE  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } fade_state_e;

endpackage

// File: rtl/pwm_fade_channel.sv
// One fade channel: ramps its threshold one LSB per interval toward the latched target.
// A load while ramping (only issued in the PWM_FADE_PREEMPT_EN build) retargets in place.
module pwm_fade_channel
  import pwm_fade_pkg::*;
#(
  parameter int unsigned BITS       = BITS_DEF,
  parameter int unsigned INTERVAL_W = INTERVAL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [BITS-1:0]       target_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  output logic [BITS-1:0]       threshold_o,
  output logic                  busy_o,
  output logic                  done_o
);

  fade_state_e           state_q;
  logic [BITS-1:0]       thr_q;
  logic [BITS-1:0]       tgt_q;
  logic [INTERVAL_W-1:0] ivl_q;
  logic [INTERVAL_W-1:0] cnt_q;
  logic                  done_q;

  logic [INTERVAL_W-1:0] ivl_d;
  logic [BITS-1:0]       thr_d;
  logic                  step_c;

  // Zero interval behaves as one cycle per step; next threshold follows ramp direction.
  assign ivl_d  = (interval_i == '0) ? INTERVAL_W'(1) : interval_i;
  assign step_c = (cnt_q == (ivl_q - INTERVAL_W'(1)));
  assign thr_d  = (state_q == RAMP_UP) ? (thr_q + BITS'(1)) : (thr_q - BITS'(1));

  // Channel FSM, interval counter and threshold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      thr_q   <= '0;
      tgt_q   <= '0;
      ivl_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        tgt_q <= target_i;
        ivl_q <= ivl_d;
        cnt_q <= '0;
        if (target_i > thr_q) begin
          state_q <= RAMP_UP;
        end else if (target_i < thr_q) begin
          state_q <= RAMP_DOWN;
        end else begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end else if (state_q != IDLE) begin
        if (step_c) begin
          cnt_q <= '0;
          thr_q <= thr_d;
          if (thr_d == tgt_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + INTERVAL_W'(1);
        end
      end
    end
  end

  assign threshold_o = thr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Command-driven fade scheduler for a bank of PWM channels.
// Optional build macro: PWM_FADE_PREEMPT_EN (accept commands to busy channels and retarget).
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int unsigned BITS       = BITS_DEF,
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned INTERVAL_W = INTERVAL_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_ch,
  input  logic [BITS-1:0]        cmd_target,
  input  logic [INTERVAL_W-1:0]  cmd_interval,
  output logic [NUM_CH*BITS-1:0] threshold,
  output logic [NUM_CH-1:0]      busy,
  output logic [NUM_CH-1:0]      done_pulse
);

  // cmd_ch can address four slots; slots beyond NUM_CH read as never busy.
  localparam int unsigned CH_SLOTS = 4;

  logic [CH_SLOTS-1:0] busy_ext;
  logic                accept_c;

  assign busy_ext = CH_SLOTS'(busy);

  // Ready depends only on reset, the addressed channel and registered busy.
`ifdef PWM_FADE_PREEMPT_EN
  assign cmd_ready = !rst;
`else
  assign cmd_ready = !rst && !busy_ext[cmd_ch];
`endif

  assign accept_c = cmd_valid && cmd_ready;

  // One independent fade channel per output slice; out-of-range commands load nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load_c;
    assign load_c = accept_c && (cmd_ch == 2'(i));

    pwm_fade_channel #(
      .BITS       (BITS),
      .INTERVAL_W (INTERVAL_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_c),
      .target_i    (cmd_target),
      .interval_i  (cmd_interval),
      .threshold_o (threshold[i*BITS +: BITS]),
      .busy_o      (busy[i]),
      .done_o      (done_pulse[i])
    );
  end

endmodule
